// File: rtl/score_pkg.sv
// Shared widths, limits and FSM encoding for the score_keeper slice.
package score_pkg;

  localparam int SCORE_W     = 20;
  localparam int SCORE_MAX_C = 999_999;
  localparam int COMBO_W     = 4;
  localparam int PTS_W       = 8;
  localparam int PROD_W      = 11;
  localparam int SUM_W       = SCORE_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ADD
  } score_state_t;

endpackage

// File: rtl/score_keeper_if.sv
// Point-event valid/ready handshake between the game logic and score_keeper.
interface score_keeper_if;
  import score_pkg::*;

  logic             pts_valid;
  logic             pts_ready;
  logic [PTS_W-1:0] pts;

  modport master (output pts_valid, output pts, input pts_ready);
  modport slave  (input pts_valid, input pts, output pts_ready);
endinterface

// File: rtl/combo_timer.sv
// Combo multiplier register with an idle timeout that drops it back to 1.
module combo_timer
  import score_pkg::*;
#(
  parameter int COMBO_MAX     = 8,
  parameter int COMBO_TIMEOUT = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               miss,
  input  logic               accept,
  output logic [COMBO_W-1:0] combo
);

  localparam int TW = (COMBO_TIMEOUT > 1) ? $clog2(COMBO_TIMEOUT) : 1;

  logic [TW-1:0] timer;
  logic          armed;
  logic          expire;

  // The timer only runs after a scoring accept and parks at 0 once it fires.
  assign expire = armed && (timer == TW'(COMBO_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || miss) begin
      combo <= COMBO_W'(1);
      timer <= '0;
      armed <= 1'b0;
    end else if (expire) begin
      combo <= COMBO_W'(1);
      timer <= '0;
      armed <= 1'b0;
    end else if (accept) begin
      if (combo != COMBO_W'(COMBO_MAX))
        combo <= combo + COMBO_W'(1);
      timer <= '0;
      armed <= 1'b1;
    end else if (armed) begin
      timer <= timer + TW'(1);
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Accepts point events, scales them by the combo multiplier and accumulates a
// saturating score plus the session high score.
module score_keeper
  import score_pkg::*;
#(
  parameter int SCORE_MAX     = SCORE_MAX_C,
  parameter int COMBO_MAX     = 8,
  parameter int COMBO_TIMEOUT = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  score_keeper_if.slave      bus,
  input  logic               miss,
  input  logic               clear,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hiscore,
  output logic [COMBO_W-1:0] combo,
  output logic               score_upd,
  output logic               saturated
);

  score_state_t state, state_nx;

  logic               accept;
  logic [PTS_W-1:0]   pts_q;
  logic [COMBO_W-1:0] combo_q;
  logic [PROD_W-1:0]  prod_q;
  logic [SUM_W-1:0]   sum;
  logic               sum_sat;
  logic [SCORE_W-1:0] new_score;

  assign bus.pts_ready = (state == IDLE) && !clear && !rst;
  assign accept        = bus.pts_valid && bus.pts_ready;

  combo_timer #(
    .COMBO_MAX     (COMBO_MAX),
    .COMBO_TIMEOUT (COMBO_TIMEOUT)
  ) u_combo (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .miss   (miss),
    .accept (accept && (bus.pts != '0)),
    .combo  (combo)
  );

  always_ff @(posedge clk) begin
    if (rst || clear)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = MUL;
      MUL:     state_nx = ADD;
      ADD:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sum       = {1'b0, score} + SUM_W'(prod_q);
    sum_sat   = (sum >= SUM_W'(SCORE_MAX));
    new_score = sum_sat ? SCORE_W'(SCORE_MAX) : sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      score     <= '0;
      hiscore   <= '0;
      score_upd <= 1'b0;
      saturated <= 1'b0;
      pts_q     <= '0;
      combo_q   <= '0;
      prod_q    <= '0;
    end else begin
      score_upd <= 1'b0;
      if (clear) begin
        score     <= '0;
        saturated <= 1'b0;
      end else begin
        // Capture the multiplier before the combo register advances this edge.
        if (accept) begin
          pts_q   <= bus.pts;
          combo_q <= combo;
        end
        if (state == MUL)
          prod_q <= PROD_W'(pts_q) * PROD_W'(combo_q);
        if (state == ADD) begin
          score     <= new_score;
          score_upd <= (new_score != score);
          if (sum_sat)
            saturated <= 1'b1;
          if (new_score > hiscore)
            hiscore <= new_score;
        end
      end
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed and randomized checks of score_keeper against a cycle-level
// behavioural model of the scoring rules.
module tb_score_keeper;
  import score_pkg::*;

  localparam int T    = 16;
  localparam int CMAX = 8;
  localparam int SMAX = 999_999;

  logic               clk;
  logic               rst;
  logic               miss;
  logic               clear;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] hiscore;
  logic [COMBO_W-1:0] combo;
  logic               score_upd;
  logic               saturated;

  score_keeper_if bus();

  score_keeper #(
    .SCORE_MAX     (SMAX),
    .COMBO_MAX     (CMAX),
    .COMBO_TIMEOUT (T)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .miss      (miss),
    .clear     (clear),
    .score     (score),
    .hiscore   (hiscore),
    .combo     (combo),
    .score_upd (score_upd),
    .saturated (saturated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: score arithmetic in plain integers.
  int m_score, m_hi, m_combo, m_prod, m_busy, m_idle;
  bit m_upd, m_sat, m_armed;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready(input bit r, input bit c);
    return !r && !c && (m_busy == 0);
  endfunction

  task automatic model_step(input bit r, input bit c, input bit ms, input bit v,
                            input int p, input bit rdy);
    bit acc;
    int sum;
    acc   = v && rdy;
    m_upd = 1'b0;
    if (r) begin
      m_score = 0; m_hi = 0; m_combo = 1; m_sat = 0;
      m_busy = 0; m_armed = 0; m_idle = 0;
    end else if (c) begin
      m_score = 0; m_sat = 0; m_combo = 1;
      m_busy = 0; m_armed = 0; m_idle = 0;
    end else begin
      if (m_busy == 1) begin
        sum = m_score + m_prod;
        if (sum >= SMAX) begin
          sum   = SMAX;
          m_sat = 1;
        end
        m_upd   = (sum != m_score);
        m_score = sum;
        if (sum > m_hi) m_hi = sum;
        m_busy = 0;
      end else if (m_busy == 2) begin
        m_busy = 1;
      end
      if (acc) begin
        m_prod = p * m_combo;
        m_busy = 2;
      end
      if (ms) begin
        m_combo = 1; m_armed = 0; m_idle = 0;
      end else if (m_armed && (m_idle == T - 1)) begin
        m_combo = 1; m_armed = 0; m_idle = 0;
      end else if (acc && p != 0) begin
        if (m_combo < CMAX) m_combo++;
        m_armed = 1; m_idle = 0;
      end else if (m_armed) begin
        m_idle++;
      end
    end
  endtask

  // One clock cycle: drive after the falling edge, check ready, step the model
  // at the rising edge, check registered outputs at the next falling edge.
  task automatic tick(input bit r, input bit c, input bit ms, input bit v,
                      input int p, output bit acc);
    bit rdy;
    rst = r; clear = c; miss = ms;
    bus.pts_valid = v; bus.pts = PTS_W'(p);
    rdy = m_ready(r, c);
    #1;
    check("pts_ready", 32'(bus.pts_ready), 32'(rdy));
    acc = v && rdy;
    @(posedge clk);
    model_step(r, c, ms, v, p, rdy);
    @(negedge clk);
    check("score", 32'(score), m_score);
    check("hiscore", 32'(hiscore), m_hi);
    check("combo", 32'(combo), m_combo);
    check("score_upd", 32'(score_upd), 32'(m_upd));
    check("saturated", 32'(saturated), 32'(m_sat));
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, a);
  endtask

  // Offer one event until accepted, then let it complete.
  task automatic send(input int p, input bit ms);
    bit a;
    a = 0;
    for (int i = 0; i < 10 && !a; i++)
      tick(0, 0, ms && m_ready(0, 0), 1, p, a);
    if (!a) check("send_accept", 0, 1);
    idle(2);
  endtask

  initial begin
    bit a;
    rst = 1; clear = 0; miss = 0; bus.pts_valid = 0; bus.pts = '0;
    m_score = 0; m_hi = 0; m_combo = 1; m_prod = 0; m_busy = 0; m_idle = 0;
    m_upd = 0; m_sat = 0; m_armed = 0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 0, a);
    check("reset_score", 32'(score), 0);
    check("reset_combo", 32'(combo), 1);
    idle(1);

    send(10, 0); check("run1", 32'(score), 10);
    send(10, 0); check("run2", 32'(score), 30);
    send(10, 0); check("run3", 32'(score), 60);
    check("run_combo", 32'(combo), 4);

    tick(0, 1, 0, 0, 0, a);
    send(5, 0); check("to1", 32'(score), 5);
    idle(20);
    check("to_combo", 32'(combo), 1);
    send(5, 0); check("to2", 32'(score), 10);

    tick(0, 1, 0, 0, 0, a);
    send(1, 0); send(1, 0);
    check("miss_pre", 32'(combo), 3);
    send(10, 1);
    check("miss_score", 32'(score), 33);
    check("miss_combo", 32'(combo), 1);

    tick(0, 1, 0, 0, 0, a);
    send(100, 0); check("clr_hi", 32'(hiscore), 100);
    tick(0, 0, 0, 1, 100, a);
    tick(0, 1, 0, 0, 0, a);
    idle(3);
    check("clr_score", 32'(score), 0);
    check("clr_hiscore", 32'(hiscore), 100);
    send(50, 0);
    check("low_game_hi", 32'(hiscore), 100);

    tick(0, 1, 0, 0, 0, a);
    for (int i = 0; i < 600 && !m_sat; i++) send(255, 0);
    check("sat_score", 32'(score), SMAX);
    check("sat_flag", 32'(saturated), 1);
    send(255, 0);
    check("sat_upd", 32'(score_upd), 0);
    check("sat_hi", 32'(hiscore), SMAX);

    tick(1, 0, 0, 0, 0, a);
    for (int i = 0; i < 3000; i++) begin
      int p;
      p = ($urandom_range(7) == 0) ? 0 :
          ($urandom_range(3) == 0) ? 255 : int'($urandom_range(255));
      tick($urandom_range(499) == 0, $urandom_range(79) == 0,
           $urandom_range(19) == 0, $urandom_range(9) < 6, p, a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
